// File: rtl/gene_net_analyzer_pkg.sv
// Shared widths, default history depth and the network state type.
package gene_net_analyzer_pkg;

    localparam int unsigned STATE_W        = 8;
    localparam int unsigned HIST_DEPTH_DEF = 8;

    // Gene 0 is the MSB of the state word.
    typedef logic [0:STATE_W-1] state_t;

endpackage

// File: rtl/gene_net_step.sv
// One synchronous update of the gene network: every gene copies its left
// neighbour (ring), except gene 4 which is the AND of genes 3 and 5.
module gene_net_step
    import gene_net_analyzer_pkg::*;
(
    input  state_t status,
    output state_t next_c
);

    always_comb begin
        next_c = {status[7], status[0:2], status[3] & status[5], status[4:6]};
    end

endmodule

// File: rtl/gene_net_analyzer.sv
// Steps the gene network once per clock and flags fixed points and short
// cycles by comparing each new successor against a shift history of successors.
module gene_net_analyzer
    import gene_net_analyzer_pkg::*;
#(
    parameter int unsigned HIST_DEPTH = HIST_DEPTH_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  state_t status,
    output state_t next_status,
    output logic   is_fixed,
    output logic   is_cycle
);

    state_t                step_c;
    state_t                next_status_q, next_status_d;
    logic                  next_vld_q, next_vld_d;
    state_t                hist_q [1:HIST_DEPTH];
    state_t                hist_d [1:HIST_DEPTH];
    logic [HIST_DEPTH:1]   hist_vld_q, hist_vld_d;
    logic                  is_fixed_q, is_fixed_d;
    logic                  is_cycle_q, is_cycle_d;
    logic                  older_hit_c;

    gene_net_step u_step (
        .status (status),
        .next_c (step_c)
    );

    // Flags are computed from the post-step register contents so they line up
    // with the next_status they describe, without a path from status to output.
    always_comb begin
        next_status_d = step_c;
        next_vld_d    = 1'b1;
        hist_d[1]     = next_status_q;
        hist_vld_d[1] = next_vld_q;
        for (int k = 2; k <= int'(HIST_DEPTH); k++) begin
            hist_d[k]     = hist_q[k-1];
            hist_vld_d[k] = hist_vld_q[k-1];
        end

        is_fixed_d = next_vld_d && hist_vld_d[1] && (next_status_d == hist_d[1]);

        older_hit_c = 1'b0;
        for (int k = 2; k <= int'(HIST_DEPTH); k++) begin
            if (hist_vld_d[k] && (next_status_d == hist_d[k])) begin
                older_hit_c = 1'b1;
            end
        end
        is_cycle_d = next_vld_d && !is_fixed_d && older_hit_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_status_q <= '0;
            next_vld_q    <= 1'b0;
            hist_vld_q    <= '0;
            is_fixed_q    <= 1'b0;
            is_cycle_q    <= 1'b0;
            for (int k = 1; k <= int'(HIST_DEPTH); k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            next_status_q <= next_status_d;
            next_vld_q    <= next_vld_d;
            hist_vld_q    <= hist_vld_d;
            is_fixed_q    <= is_fixed_d;
            is_cycle_q    <= is_cycle_d;
            for (int k = 1; k <= int'(HIST_DEPTH); k++) begin
                hist_q[k] <= hist_d[k];
            end
        end
    end

    assign next_status = next_status_q;
    assign is_fixed    = is_fixed_q;
    assign is_cycle    = is_cycle_q;

endmodule

// File: tb/tb_gene_net_analyzer.sv
// Self-checking bench for gene_net_analyzer: directed trajectories plus a
// randomized run against a trajectory-list reference model.
module tb_gene_net_analyzer;

    localparam int H = 8;

    logic       clk;
    logic       reset;
    logic [0:7] status;
    logic [0:7] next_status;
    logic       is_fixed;
    logic       is_cycle;

    int checks = 0;
    int errors = 0;

    // Reference model: successors produced since the last reset, newest last.
    logic [7:0] traj [$];
    logic [7:0] exp_next;
    logic       exp_fix;
    logic       exp_cyc;

    gene_net_analyzer #(.HIST_DEPTH(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .status      (status),
        .next_status (next_status),
        .is_fixed    (is_fixed),
        .is_cycle    (is_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Genes shift one place toward the LSB (numeric rotate right); gene 4
    // (numeric bit 3) becomes gene3 AND gene5 (numeric bits 4 and 2).
    function automatic logic [7:0] f_ref(input logic [7:0] v);
        logic [7:0] r;
        r    = {v[0], v[7:1]};
        r[3] = v[4] & v[2];
        return r;
    endfunction

    // Drive one clock and advance the model; comparisons live in the tests.
    task automatic do_step(input logic [7:0] s, input logic r);
        int n;
        @(negedge clk);
        status = s;
        reset  = r;
        @(posedge clk);
        #1;
        if (r) begin
            traj.delete();
            exp_next = 8'h00;
            exp_fix  = 1'b0;
            exp_cyc  = 1'b0;
        end else begin
            traj.push_back(f_ref(s));
            if (traj.size() > H + 1) void'(traj.pop_front());
            n        = traj.size();
            exp_next = traj[n-1];
            exp_fix  = (n >= 2) && (traj[n-1] == traj[n-2]);
            exp_cyc  = 1'b0;
            if (!exp_fix) begin
                for (int k = 2; k <= H; k++) begin
                    if (n > k && traj[n-1] == traj[n-1-k]) exp_cyc = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_step(8'h5A, 1'b1);
        checks++;
        if ({next_status, is_fixed, is_cycle} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got %b/%b/%b want 00000000/0/0", next_status, is_fixed, is_cycle);
        end
    endtask

    task automatic test_fixed_zero();
        logic [9:0] want [2];
        want[0] = {8'b00000000, 2'b00};
        want[1] = {8'b00000000, 2'b10};
        do_step(8'h00, 1'b1);
        do_step(8'b00000000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) do_step(exp_next, 1'b0);
            checks++;
            if ({next_status, is_fixed, is_cycle} !== want[i]) begin
                errors++;
                $display("FAIL fixed_zero step%0d: got %b/%b/%b want %b", i + 1, next_status, is_fixed, is_cycle, want[i]);
            end
        end
    endtask

    task automatic test_fixed_ones();
        logic [9:0] want [2];
        want[0] = {8'b11111111, 2'b00};
        want[1] = {8'b11111111, 2'b10};
        do_step(8'h00, 1'b1);
        do_step(8'b11111111, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) do_step(exp_next, 1'b0);
            checks++;
            if ({next_status, is_fixed, is_cycle} !== want[i]) begin
                errors++;
                $display("FAIL fixed_ones step%0d: got %b/%b/%b want %b", i + 1, next_status, is_fixed, is_cycle, want[i]);
            end
        end
    endtask

    task automatic run_alt(input string tag);
        logic [9:0] want [3];
        want[0] = {8'b01010101, 2'b00};
        want[1] = {8'b10101010, 2'b00};
        want[2] = {8'b01010101, 2'b01};
        do_step(8'b10101010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) do_step(exp_next, 1'b0);
            checks++;
            if ({next_status, is_fixed, is_cycle} !== want[i]) begin
                errors++;
                $display("FAIL %s step%0d: got %b/%b/%b want %b", tag, i + 1, next_status, is_fixed, is_cycle, want[i]);
            end
        end
    endtask

    task automatic test_cycle_alt();
        do_step(8'h00, 1'b1);
        run_alt("cycle_alt");
    endtask

    task automatic test_transient();
        do_step(8'h00, 1'b1);
        do_step(8'b00001111, 1'b0);
        checks++;
        if ({next_status, is_fixed, is_cycle} !== {8'b10000111, 2'b00}) begin
            errors++;
            $display("FAIL transient step1: got %b/%b/%b want 10000111/0/0", next_status, is_fixed, is_cycle);
        end
        do_step(exp_next, 1'b0);
        checks++;
        if ({next_status, is_fixed, is_cycle} !== {8'b11000011, 2'b00}) begin
            errors++;
            $display("FAIL transient step2: got %b/%b/%b want 11000011/0/0", next_status, is_fixed, is_cycle);
        end
    endtask

    task automatic test_reset_mid_cycle();
        do_step(8'h00, 1'b1);
        run_alt("pre_reset");
        do_step(exp_next, 1'b1);
        checks++;
        if ({next_status, is_fixed, is_cycle} !== {8'h00, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid_cycle: got %b/%b/%b want 00000000/0/0", next_status, is_fixed, is_cycle);
        end
        run_alt("post_reset");
    endtask

    // Status not equal to the stored successor must not disturb history matching.
    task automatic test_status_jump();
        do_step(8'h00, 1'b1);
        do_step(8'b10101010, 1'b0);
        do_step(8'b00001111, 1'b0);
        do_step(8'b10101010, 1'b0);
        checks++;
        if ({next_status, is_fixed, is_cycle} !== {8'b01010101, 2'b01}) begin
            errors++;
            $display("FAIL status_jump: got %b/%b/%b want 01010101/0/1", next_status, is_fixed, is_cycle);
        end
    endtask

    task automatic test_random();
        logic [7:0] s;
        logic       r;
        do_step(8'h00, 1'b1);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 4) != 0) ? exp_next : 8'($urandom);
            do_step(s, r);
            checks++;
            if ({next_status, is_fixed, is_cycle} !== {exp_next, exp_fix, exp_cyc}) begin
                errors++;
                $display("FAIL random[%0d]: got %b/%b/%b want %b/%b/%b", i, next_status, is_fixed, is_cycle, exp_next, exp_fix, exp_cyc);
            end
            checks++;
            if (is_fixed && is_cycle) begin
                errors++;
                $display("FAIL flags_exclusive[%0d]: got fixed=%b cycle=%b want not both 1", i, is_fixed, is_cycle);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        status   = '0;
        exp_next = 8'h00;
        exp_fix  = 1'b0;
        exp_cyc  = 1'b0;
        test_reset();
        test_fixed_zero();
        test_fixed_ones();
        test_cycle_alt();
        test_transient();
        test_reset_mid_cycle();
        test_status_jump();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gene_net_analyzer.md
GENE_NET_ANALYZER -- requirements
Module: gene_net_analyzer

Interface
REQ-001 SHALL have parameter HIST_DEPTH, default 8, meaning number of past states compared for cycle detection (legal 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high; clears all state.
REQ-004 SHALL have port status  input  [0:7]  current network state; bit 0 is MSB, gene i = status[i].
REQ-005 SHALL have port next_status  output  [0:7]  registered successor state.
REQ-006 SHALL have port is_fixed  output  1  high when the network has reached a fixed point.
REQ-007 SHALL have port is_cycle  output  1  high when the network has entered a cycle of period 2..HIST_DEPTH.

Function
REQ-008 Update rule f, with s = status: n[i] = s[(i+7) mod 8] for all i except 4; n[4] = s[3] & s[5].
REQ-009 On each rising clk with reset=0: next_status <= f(status); one step per clock; latency 1 clock.
REQ-010 Each step SHALL shift the previous next_status into history slot 1 and slot k-1 into slot k (k up to HIST_DEPTH); the oldest entry is discarded.
REQ-011 A valid bit per register: next_status valid after the first step; history valid bits shift with the data.
REQ-012 is_fixed = next_status valid & hist[1] valid & (next_status == hist[1]); derived only from registers, no combinational path from status.
REQ-013 is_cycle = next_status valid & not is_fixed & (some k in 2..HIST_DEPTH with hist[k] valid and next_status == hist[k]).
REQ-014 is_fixed and is_cycle SHALL never both be 1.
REQ-015 Flags are not sticky; they follow the stored trajectory each clock.
REQ-016 Status input changing arbitrarily between steps (not equal to next_status) is legal; comparison uses stored successor states only.
REQ-017 Cycles longer than HIST_DEPTH SHALL NOT set is_cycle.

Reset
REQ-018 With reset=1 at a rising edge: next_status <= 8'b0, all history and valid bits cleared, is_fixed=0, is_cycle=0.
REQ-019 Reset SHALL take priority over a step in the same cycle; reset mid-trajectory discards all history.
REQ-020 The first step after reset SHALL behave exactly as from power-up reset.

Structure
REQ-021 Shared package SHALL hold STATE_W=8, default HIST_DEPTH, and the state typedef logic [0:7].
REQ-022 Update rule f SHALL be a combinational sub-module gene_net_step (status in, next out); history and flag logic in the top.

Verification
REQ-023 reset; status=00000000, feed back 2 steps -> next_status=00000000, is_fixed=1 after step 2, is_cycle=0.
REQ-024 reset; status=11111111, feed back -> next_status=11111111, is_fixed=1 after step 2.
REQ-025 reset; status=10101010, feed back -> 01010101, 10101010, 01010101; is_cycle=1 after step 3, is_fixed=0.
REQ-026 reset; status=00001111 -> step1 10000111, step2 11000011, flags 0 after both steps.
REQ-027 Reset asserted while is_cycle=1 -> next cycle: next_status=0, both flags 0; fresh 10101010 run again needs 3 steps for is_cycle.
REQ-028 Random status sequence versus reference model of f and history; assert flags never both high.
